// File: rtl/eth_fcs_crc32.sv
// Streaming Ethernet FCS (CRC-32) calculator.
// Accumulates a reflected-input CRC-32 over the enabled bytes of each accepted beat, counts
// frame bytes (saturating) and flags keep-pattern framing errors. At end of frame it publishes
// FCS, length and error through a single-entry result register with a valid/ready handshake.
module eth_fcs_crc32 #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk156,
    input  logic                  eth_rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [31:0]           res_fcs,
    output logic [15:0]           res_len,
    output logic                  res_err,
    output logic                  res_valid,
    input  logic                  res_ready
);

    localparam logic [31:0]           CrcPoly = 32'h04C11DB7;
    localparam logic [31:0]           CrcInit = 32'hFFFF_FFFF;
    localparam int unsigned           PopW    = $clog2(KEEP_WIDTH + 1);
    localparam logic [KEEP_WIDTH-1:0] KeepOne = KEEP_WIDTH'(1);
    localparam logic [KEEP_WIDTH-1:0] KeepAll = '1;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_width
        $error("eth_fcs_crc32: DATA_WIDTH must be 32 or 64 and KEEP_WIDTH = DATA_WIDTH/8");
    end

    typedef enum logic {StIdle, StAcc} state_e;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Non-reflected shift register fed with bit-reversed bytes, i.e. LSB of each byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] s;
        logic [7:0]  d;
        logic        fb;
        s = c;
        d = bit_reverse8(b);
        for (int i = 7; i >= 0; i--) begin
            fb = s[31] ^ d[i];
            s  = {s[30:0], 1'b0};
            if (fb) s = s ^ CrcPoly;
        end
        return s;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_fcs_q, res_fcs_d;
    logic [15:0] res_len_q, res_len_d;
    logic        res_err_q, res_err_d;

    logic            beat_acc;
    logic [31:0]     crc_base, crc_beat;
    logic [15:0]     cnt_base, cnt_beat;
    logic            err_base, beat_err, keep_contig;
    logic [PopW-1:0] pop;

    // A last beat may only enter when the result slot is free or being freed this cycle.
    assign s_tready = ~res_valid_q | res_ready | ~(s_tvalid & s_tlast);
    assign beat_acc = s_tvalid & s_tready;

    // Per-beat CRC, byte count and keep-pattern checks, starting from fresh values in idle.
    always_comb begin
        crc_base = (state_q == StIdle) ? CrcInit : crc_q;
        cnt_base = (state_q == StIdle) ? 16'h0000 : cnt_q;
        err_base = (state_q == StIdle) ? 1'b0 : err_q;
        crc_beat = crc_base;
        pop      = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (s_tkeep[i]) begin
                crc_beat = crc_byte(crc_beat, s_tdata[8*i +: 8]);
                pop      = pop + PopW'(1);
            end
        end
        // Compare against headroom before adding so the counter can never wrap.
        cnt_beat    = (cnt_base > (16'hFFFF - 16'(pop))) ? 16'hFFFF : cnt_base + 16'(pop);
        keep_contig = ((s_tkeep & (s_tkeep + KeepOne)) == '0);
        beat_err    = (s_tkeep == '0) | ~keep_contig | (~s_tlast & (s_tkeep != KeepAll));
    end

    // Frame FSM and result-slot next state.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        res_valid_d = res_valid_q & ~res_ready;
        res_fcs_d   = res_fcs_q;
        res_len_d   = res_len_q;
        res_err_d   = res_err_q;
        if (beat_acc) begin
            if (s_tlast) begin
                res_valid_d = 1'b1;
                res_fcs_d   = bit_reverse32(~crc_beat);
                res_len_d   = cnt_beat;
                res_err_d   = err_base | beat_err;
                crc_d       = CrcInit;
                cnt_d       = 16'h0000;
                err_d       = 1'b0;
                state_d     = StIdle;
            end else begin
                crc_d   = crc_beat;
                cnt_d   = cnt_beat;
                err_d   = err_base | beat_err;
                state_d = StAcc;
            end
        end
    end

    // State registers with synchronous reset; an in-flight frame is simply dropped.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q     <= StIdle;
            crc_q       <= CrcInit;
            cnt_q       <= 16'h0000;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_fcs_q   <= 32'h0000_0000;
            res_len_q   <= 16'h0000;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_fcs_q   <= res_fcs_d;
            res_len_q   <= res_len_d;
            res_err_q   <= res_err_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_fcs   = res_fcs_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_eth_fcs_crc32.sv
// Self-checking bench for eth_fcs_crc32: table of whole frames plus directed corner sequences.
module tb_eth_fcs_crc32;

    logic        clk156 = 1'b0;
    logic        eth_rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] res_fcs;
    logic [15:0] res_len;
    logic        res_err;
    logic        res_valid;
    logic        res_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk156 = ~clk156;

    eth_fcs_crc32 #(.DATA_WIDTH(64)) dut (
        .clk156    (clk156),
        .eth_rst   (eth_rst),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .res_fcs   (res_fcs),
        .res_len   (res_len),
        .res_err   (res_err),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    typedef struct {
        string       txt;
        logic        use_model;
        logic [31:0] fcs;
        logic [15:0] len;
    } frame_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: classic reflected CRC-32 (poly 0xEDB88320), byte at a time.
    function automatic logic [31:0] ref_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] s;
        s = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) s = s[0] ? ((s >> 1) ^ 32'hEDB88320) : (s >> 1);
        return s;
    endfunction

    function automatic logic [31:0] ref_str(input string s);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < s.len(); i++) c = ref_upd(c, 8'(s[i]));
        return ~c;
    endfunction

    task automatic pack(input string s, input int off, output logic [63:0] d,
                        output logic [7:0] k);
        d = '0;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (off + i < s.len()) begin
                d[8*i +: 8] = 8'(s[off+i]);
                k[i]        = 1'b1;
            end
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic last);
        int waited;
        waited = 0;
        @(negedge clk156);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = last;
        s_tvalid = 1'b1;
        #1;
        while (!s_tready && waited < 50) begin
            @(negedge clk156);
            #1;
            waited++;
        end
        if (!s_tready) chk("tready_timeout", 32'(s_tready), 32'd1);
        @(posedge clk156);
    endtask

    task automatic send_str(input string s);
        logic [63:0] d;
        logic [7:0]  k;
        for (int off = 0; off < s.len(); off += 8) begin
            pack(s, off, d, k);
            beat(d, k, (off + 8 >= s.len()));
        end
    endtask

    // Called right after the last-beat accept: result must be valid one cycle later.
    task automatic get_result(input string name, input logic [31:0] fcs, input logic [15:0] len,
                              input logic err);
        @(negedge clk156);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk({name, "_valid"}, 32'(res_valid), 32'd1);
        chk({name, "_fcs"}, res_fcs, fcs);
        chk({name, "_len"}, 32'(res_len), 32'(len));
        chk({name, "_err"}, 32'(res_err), 32'(err));
        res_ready = 1'b1;
        @(posedge clk156);
        @(negedge clk156);
        res_ready = 1'b0;
        chk({name, "_retired"}, 32'(res_valid), 32'd0);
    endtask

    frame_vec_t vecs[6];

    initial begin
        logic [63:0] d;
        logic [7:0]  k;
        logic [31:0] mc;
        logic [7:0]  bv;

        vecs[0] = '{"a", 1'b0, 32'hE8B7BE43, 16'd1};
        vecs[1] = '{"abc", 1'b0, 32'h352441C2, 16'd3};
        vecs[2] = '{"123456789", 1'b0, 32'hCBF43926, 16'd9};
        vecs[3] = '{"The quick brown fox jumps over the lazy dog", 1'b0, 32'h414FA339, 16'd43};
        vecs[4] = '{"12345678", 1'b1, 32'h0, 16'd8};
        vecs[5] = '{"0123456789abcdef", 1'b1, 32'h0, 16'd16};

        eth_rst   = 1'b1;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk156);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_fcs", res_fcs, 32'd0);
        chk("rst_len", 32'(res_len), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        eth_rst = 1'b0;

        // Single zero byte; junk in disabled lanes must be ignored.
        beat(64'hFFFF_FFFF_FFFF_FF00, 8'h01, 1'b1);
        get_result("zero", 32'hD202EF8D, 16'd1, 1'b0);

        for (int v = 0; v < 6; v++) begin
            send_str(vecs[v].txt);
            get_result($sformatf("vec%0d", v),
                       vecs[v].use_model ? ref_str(vecs[v].txt) : vecs[v].fcs,
                       vecs[v].len, 1'b0);
        end

        // Back-to-back frames with the result never read: last beat must stall.
        beat(64'h61, 8'h01, 1'b1);
        pack("12345678", 0, d, k);
        beat(d, k, 1'b0);
        @(negedge clk156);
        s_tdata  = 64'h39;
        s_tkeep  = 8'h01;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall%0d", i), 32'(s_tready), 32'd0);
            chk($sformatf("bp_hold_fcs%0d", i), res_fcs, 32'hE8B7BE43);
            chk($sformatf("bp_hold_valid%0d", i), 32'(res_valid), 32'd1);
            @(negedge clk156);
        end
        chk("bp_hold_len", 32'(res_len), 32'd1);
        res_ready = 1'b1;
        #1;
        chk("bp_release", 32'(s_tready), 32'd1);
        @(posedge clk156);
        @(negedge clk156);
        res_ready = 1'b0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        chk("bp_swap_valid", 32'(res_valid), 32'd1);
        chk("bp_swap_fcs", res_fcs, 32'hCBF43926);
        chk("bp_swap_len", 32'(res_len), 32'd9);
        res_ready = 1'b1;
        @(posedge clk156);
        @(negedge clk156);
        res_ready = 1'b0;
        chk("bp_retired", 32'(res_valid), 32'd0);

        // Short non-last beat, then a full last beat.
        pack("ABCD", 0, d, k);
        d[63:32] = 32'hEEEE_EEEE;
        beat(d, k, 1'b0);
        pack("EFGHIJKL", 0, d, k);
        beat(d, k, 1'b1);
        get_result("short_mid", ref_str("ABCDEFGHIJKL"), 16'd12, 1'b1);

        // Non-contiguous keep on a last beat: lanes 0 and 2 only.
        beat(64'h0000_0000_0079_EE78, 8'h05, 1'b1);
        get_result("holey", ref_str("xy"), 16'd2, 1'b1);

        // The sticky error must not leak into the next frame.
        send_str("abc");
        get_result("clean", 32'h352441C2, 16'd3, 1'b0);

        // Long frame: length saturates, CRC stays exact.
        mc = 32'hFFFF_FFFF;
        for (int b = 0; b < 8200; b++) begin
            for (int l = 0; l < 8; l++) begin
                bv          = 8'((b * 8 + l) * 7 + 3);
                d[8*l +: 8] = bv;
                mc          = ref_upd(mc, bv);
            end
            beat(d, 8'hFF, (b == 8199));
        end
        get_result("sat", ~mc, 16'hFFFF, 1'b0);

        // Reset in mid-frame discards the partial frame.
        beat(64'h1122_3344_5566_7788, 8'hFF, 1'b0);
        beat(64'h99AA_BBCC_DDEE_FF00, 8'hFF, 1'b0);
        @(negedge clk156);
        s_tvalid = 1'b0;
        eth_rst  = 1'b1;
        @(negedge clk156);
        eth_rst = 1'b0;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        repeat (2) @(negedge clk156);
        chk("midrst_quiet", 32'(res_valid), 32'd0);
        send_str("a");
        get_result("midrst_a", 32'hE8B7BE43, 16'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
